writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, architectural register count (x0 hard-wired zero).
REQ-003 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port issueValid  input  1  decode presents an instruction this cycle.
REQ-006 The block SHALL have port issueRegWrite  input  1  issuing instruction writes rd.
REQ-007 The block SHALL have port issueRd / issueRs1 / issueRs2  input  5 each  decode destination and source indices.
REQ-008 The block SHALL have port hazardStall  output  1  combinational stall request to fetch/decode.
REQ-009 The block SHALL have port memValid  input  1  memory stage delivers a completing instruction.
REQ-010 The block SHALL have port memRegWrite  input  1, memRd  input  5, memWbSel  input  2 (00 ALU, 01 memory, 10 pcPlus4, 11 ALU).
REQ-011 The block SHALL have ports memAluResult, memReadData, memPcPlus4  input  DATA_WIDTH  candidate results.
REQ-012 The block SHALL have ports registerWrite  output  1, writeRd  output  5, writeData  output  DATA_WIDTH  register-file write port.
REQ-013 The block SHALL have port retireCount  output  32  committed-instruction counter.
REQ-014 The block SHALL have port scoreboardError  output  1  sticky pending-count overflow/underflow flag.

Function
REQ-015 When memValid=1, the block SHALL capture memRd, memRegWrite and the memWbSel-selected result into the WB register on the next edge; latency is exactly 1 cycle.
REQ-016 When memValid=0, wbValid SHALL clear on the next edge; writeRd/writeData SHALL hold their last values.
REQ-017 registerWrite SHALL equal wbValid & wbRegWrite & (writeRd != 0); it is never asserted for x0.
REQ-018 A per-register 2-bit pending count SHALL be kept for registers 1..NUM_REGS-1; x0 has none.
REQ-019 An accepted issue (issueValid & !hazardStall & issueRegWrite & issueRd != 0) SHALL increment pending[issueRd] on the edge.
REQ-020 A commit (registerWrite=1) SHALL decrement pending[writeRd] on the same edge as the register-file write.
REQ-021 A simultaneous accepted issue and commit to the same register SHALL leave its count unchanged.
REQ-022 An increment at count 3 SHALL saturate at 3, and a decrement at count 0 SHALL stay at 0; either event SHALL set scoreboardError.
REQ-023 hazardStall SHALL equal issueValid & ((issueRs1 != 0 & pending[issueRs1] != 0) | (issueRs2 != 0 & pending[issueRs2] != 0)).
REQ-024 A source whose final commit occurs this cycle SHALL still stall; it is released the following cycle, when the register file holds the new value.
REQ-025 retireCount SHALL increment by 1 on every edge with wbValid=1, regardless of regWrite, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-026 On an edge with reset=1, the block SHALL clear wbValid, all pending counts, retireCount and scoreboardError, and SHALL set writeRd and writeData to 0.
REQ-027 While reset=1, registerWrite SHALL be 0, and hazardStall SHALL be 0 from the first cycle after the reset edge.
REQ-028 Reset SHALL take priority over simultaneous issue, commit or memValid; in-flight results are discarded.

Structure
REQ-029 DATA_WIDTH, NUM_REGS and the wbSel encoding enum SHALL live in the shared processor package.
REQ-030 Pending counts, hazard compare and error flag SHALL be one sub-module, pendingScoreboard; the result mux, WB register and retire counter remain in writeback_unit.

Verification
REQ-031 Reset, then memValid=1, memRd=5, memWbSel=00, memAluResult=0x1234 -> next cycle registerWrite=1, writeRd=5, writeData=0x1234, retireCount=1.
REQ-032 memWbSel=01, memReadData=0xDEADBEEF, memRd=0, memRegWrite=1 -> writeData=0xDEADBEEF, registerWrite=0, retireCount increments.
REQ-033 Issue rd=3 (accepted), then issueRs1=3 -> hazardStall=1 until the cycle after registerWrite for rd=3, then 0.
REQ-034 Issue to rd=7 in the same cycle that commit rd=7 occurs, with count 1 -> count stays 1, hazardStall remains 1 for a reader of x7.
REQ-035 Four accepted issues to rd=9 with no commits -> scoreboardError=1 and the count reads 3; the next reset clears both.
REQ-036 Issue rd=4, then assert reset before commit -> pending cleared, hazardStall=0 for rs1=4, registerWrite=0.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_pkg
// Description : Shared processor constants and the writeback-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int NUM_REGS       = 32;
    localparam int REG_IDX_W      = 5;
    localparam int REG_IDX_SPACE  = 1 << REG_IDX_W;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'b00,
        WB_SEL_MEM     = 2'b01,
        WB_SEL_PC4     = 2'b10,
        WB_SEL_ALU_ALT = 2'b11
    } wb_sel_e;

endpackage
`default_nettype wire

// File: rtl/writeback_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pendingScoreboard
// Description : Per-register pending-write counts, RAW hazard detect, error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pendingScoreboard #(
    parameter int NUM_REGS = writeback_unit_pkg::NUM_REGS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issueValid,
    input  logic       issueRegWrite,
    input  logic [4:0] issueRd,
    input  logic [4:0] issueRs1,
    input  logic [4:0] issueRs2,
    input  logic       commitValid,
    input  logic [4:0] commitRd,
    output logic       hazardStall,
    output logic       scoreboardError
);
    import writeback_unit_pkg::*;

    logic [REG_IDX_SPACE-1:0] w_busy;
    logic [REG_IDX_SPACE-1:0] w_overflow;
    logic [REG_IDX_SPACE-1:0] w_underflow;
    logic                     w_accept;
    logic                     r_error;

    // A source still stalls in its commit cycle because the count only drops on that edge.
    assign hazardStall = issueValid &
                         (((issueRs1 != 5'd0) & w_busy[issueRs1]) |
                          ((issueRs2 != 5'd0) & w_busy[issueRs2]));

    assign w_accept = issueValid & ~hazardStall & issueRegWrite & (issueRd != 5'd0);

    for (genvar i = 0; i < REG_IDX_SPACE; i++) begin : g_reg
        if (i == 0 || i >= NUM_REGS) begin : g_none
            assign w_busy[i]      = 1'b0;
            assign w_overflow[i]  = 1'b0;
            assign w_underflow[i] = 1'b0;
        end else begin : g_cnt
            localparam logic [4:0] c_IDX = 5'(i);
            logic [1:0] r_cnt;
            logic       w_inc;
            logic       w_dec;

            assign w_inc = w_accept & (issueRd == c_IDX);
            assign w_dec = commitValid & (commitRd == c_IDX);

            assign w_busy[i]      = (r_cnt != 2'd0);
            assign w_overflow[i]  = w_inc & ~w_dec & (r_cnt == 2'd3);
            assign w_underflow[i] = w_dec & ~w_inc & (r_cnt == 2'd0);

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= 2'd0;
                end else if (w_inc && !w_dec && r_cnt != 2'd3) begin
                    r_cnt <= r_cnt + 2'd1;
                end else if (w_dec && !w_inc && r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if ((|w_overflow) || (|w_underflow)) begin
            r_error <= 1'b1;
        end
    end

    assign scoreboardError = r_error;

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Writeback stage: result select, WB register, retire counter, scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int DATA_WIDTH = writeback_unit_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = writeback_unit_pkg::NUM_REGS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issueValid,
    input  logic                  issueRegWrite,
    input  logic [4:0]            issueRd,
    input  logic [4:0]            issueRs1,
    input  logic [4:0]            issueRs2,
    output logic                  hazardStall,
    input  logic                  memValid,
    input  logic                  memRegWrite,
    input  logic [4:0]            memRd,
    input  logic [1:0]            memWbSel,
    input  logic [DATA_WIDTH-1:0] memAluResult,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic [DATA_WIDTH-1:0] memPcPlus4,
    output logic                  registerWrite,
    output logic [4:0]            writeRd,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic [31:0]           retireCount,
    output logic                  scoreboardError
);
    import writeback_unit_pkg::*;

    logic [DATA_WIDTH-1:0] w_result;
    logic                  r_wb_valid;
    logic                  r_wb_reg_write;
    logic [4:0]            r_write_rd;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [31:0]           r_retire;

    always_comb begin
        w_result = memAluResult;
        case (wb_sel_e'(memWbSel))
            WB_SEL_ALU:     w_result = memAluResult;
            WB_SEL_MEM:     w_result = memReadData;
            WB_SEL_PC4:     w_result = memPcPlus4;
            WB_SEL_ALU_ALT: w_result = memAluResult;
            default:        w_result = memAluResult;
        endcase
    end

    // Destination and data hold across bubbles; only the valid bit drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_write_rd     <= 5'd0;
            r_write_data   <= '0;
            r_retire       <= 32'd0;
        end else begin
            r_wb_valid <= memValid;
            if (memValid) begin
                r_wb_reg_write <= memRegWrite;
                r_write_rd     <= memRd;
                r_write_data   <= w_result;
            end
            if (r_wb_valid) begin
                r_retire <= r_retire + 32'd1;
            end
        end
    end

    assign registerWrite = r_wb_valid & r_wb_reg_write & (r_write_rd != 5'd0) & ~reset;
    assign writeRd       = r_write_rd;
    assign writeData     = r_write_data;
    assign retireCount   = r_retire;

    pendingScoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock           (clock),
        .reset           (reset),
        .issueValid      (issueValid),
        .issueRegWrite   (issueRegWrite),
        .issueRd         (issueRd),
        .issueRs1        (issueRs1),
        .issueRs2        (issueRs2),
        .commitValid     (registerWrite),
        .commitRd        (r_write_rd),
        .hazardStall     (hazardStall),
        .scoreboardError (scoreboardError)
    );

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Directed and random checks of writeback_unit against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        issueValid;
    logic        issueRegWrite;
    logic [4:0]  issueRd;
    logic [4:0]  issueRs1;
    logic [4:0]  issueRs2;
    logic        hazardStall;
    logic        memValid;
    logic        memRegWrite;
    logic [4:0]  memRd;
    logic [1:0]  memWbSel;
    logic [31:0] memAluResult;
    logic [31:0] memReadData;
    logic [31:0] memPcPlus4;
    logic        registerWrite;
    logic [4:0]  writeRd;
    logic [31:0] writeData;
    logic [31:0] retireCount;
    logic        scoreboardError;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int          pend [32];
    logic        m_wbv;
    logic        m_wbrw;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_ret;
    logic        m_err;

    always #5 clock = ~clock;

    writeback_unit dut (
        .clock           (clock),
        .reset           (reset),
        .issueValid      (issueValid),
        .issueRegWrite   (issueRegWrite),
        .issueRd         (issueRd),
        .issueRs1        (issueRs1),
        .issueRs2        (issueRs2),
        .hazardStall     (hazardStall),
        .memValid        (memValid),
        .memRegWrite     (memRegWrite),
        .memRd           (memRd),
        .memWbSel        (memWbSel),
        .memAluResult    (memAluResult),
        .memReadData     (memReadData),
        .memPcPlus4      (memPcPlus4),
        .registerWrite   (registerWrite),
        .writeRd         (writeRd),
        .writeData       (writeData),
        .retireCount     (retireCount),
        .scoreboardError (scoreboardError)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issueValid    = 1'b0;
        issueRegWrite = 1'b0;
        issueRd       = 5'd0;
        issueRs1      = 5'd0;
        issueRs2      = 5'd0;
        memValid      = 1'b0;
        memRegWrite   = 1'b0;
        memRd         = 5'd0;
        memWbSel      = 2'd0;
        memAluResult  = $urandom;
        memReadData   = $urandom;
        memPcPlus4    = $urandom;
    endtask

    task automatic model_update(input logic exp_stall, input logic exp_rw);
        logic acc;
        if (reset) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            m_wbv = 1'b0; m_wbrw = 1'b0; m_rd = 5'd0; m_data = 32'd0;
            m_ret = 32'd0; m_err = 1'b0;
        end else begin
            acc = issueValid && !exp_stall && issueRegWrite && issueRd != 5'd0;
            if (!(acc && exp_rw && issueRd == m_rd)) begin
                if (acc) begin
                    if (pend[issueRd] == 3) m_err = 1'b1;
                    else pend[issueRd] = pend[issueRd] + 1;
                end
                if (exp_rw) begin
                    if (pend[m_rd] == 0) m_err = 1'b1;
                    else pend[m_rd] = pend[m_rd] - 1;
                end
            end
            if (m_wbv) m_ret = m_ret + 32'd1;
            m_wbv = memValid;
            if (memValid) begin
                m_wbrw = memRegWrite;
                m_rd   = memRd;
                m_data = (memWbSel == 2'b01) ? memReadData :
                         (memWbSel == 2'b10) ? memPcPlus4  : memAluResult;
            end
        end
    endtask

    // Inputs are set at a falling edge; compare, then advance one cycle.
    task automatic cyc();
        logic exp_rw;
        logic exp_stall;
        #2;
        exp_rw    = m_wbv && m_wbrw && m_rd != 5'd0 && !reset;
        exp_stall = issueValid && ((issueRs1 != 5'd0 && pend[issueRs1] != 0) ||
                                   (issueRs2 != 5'd0 && pend[issueRs2] != 0));
        chk("registerWrite",   32'(registerWrite),   32'(exp_rw));
        chk("writeRd",         32'(writeRd),         32'(m_rd));
        chk("writeData",       writeData,            m_data);
        chk("retireCount",     retireCount,          m_ret);
        chk("scoreboardError", 32'(scoreboardError), 32'(m_err));
        chk("hazardStall",     32'(hazardStall),     32'(exp_stall));
        @(posedge clock);
        model_update(exp_stall, exp_rw);
        @(negedge clock);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        model_update(1'b0, 1'b0);
        @(negedge clock);
        cyc();
        reset = 1'b0;

        // Single ALU result to x5
        memValid = 1'b1; memRegWrite = 1'b1; memRd = 5'd5; memWbSel = 2'b00;
        memAluResult = 32'h0000_1234;
        cyc();
        idle(); #1;
        chk("d31_rw", 32'(registerWrite), 32'd1);
        chk("d31_rd", 32'(writeRd), 32'd5);
        chk("d31_data", writeData, 32'h0000_1234);
        cyc(); #1;
        chk("d31_retire", retireCount, 32'd1);

        // Memory load targeting x0
        memValid = 1'b1; memRegWrite = 1'b1; memRd = 5'd0; memWbSel = 2'b01;
        memReadData = 32'hDEAD_BEEF;
        cyc();
        idle(); #1;
        chk("d32_data", writeData, 32'hDEAD_BEEF);
        chk("d32_rw", 32'(registerWrite), 32'd0);
        cyc(); #1;
        chk("d32_retire", retireCount, 32'd2);

        reset = 1'b1; cyc(); reset = 1'b0;

        // RAW hazard on x3 released the cycle after its commit
        issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 5'd3;
        cyc();
        idle(); issueValid = 1'b1; issueRs1 = 5'd3; #1;
        chk("d33_stall_issued", 32'(hazardStall), 32'd1);
        cyc(); cyc();
        memValid = 1'b1; memRegWrite = 1'b1; memRd = 5'd3;
        cyc();
        memValid = 1'b0; #1;
        chk("d33_commit_rw", 32'(registerWrite), 32'd1);
        chk("d33_stall_commit", 32'(hazardStall), 32'd1);
        cyc(); #1;
        chk("d33_released", 32'(hazardStall), 32'd0);
        cyc();

        // Simultaneous issue and commit on x7
        idle(); issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 5'd7;
        cyc();
        idle(); memValid = 1'b1; memRegWrite = 1'b1; memRd = 5'd7;
        cyc();
        idle(); issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 5'd7;
        cyc();
        idle(); issueValid = 1'b1; issueRs2 = 5'd7; #1;
        chk("d34_still_pending", 32'(hazardStall), 32'd1);
        cyc();

        // Saturation on x9
        reset = 1'b1; idle(); cyc(); reset = 1'b0;
        issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 5'd9;
        repeat (4) cyc();
        idle(); #1;
        chk("d35_error", 32'(scoreboardError), 32'd1);
        issueValid = 1'b1; issueRs2 = 5'd9;
        memValid = 1'b1; memRegWrite = 1'b1; memRd = 5'd9;
        repeat (3) cyc();
        memValid = 1'b0;
        cyc(); #1;
        chk("d35_two_commits_left_zero", 32'(hazardStall), 32'd0);
        cyc();
        reset = 1'b1; idle(); cyc(); reset = 1'b0; #1;
        chk("d35_reset_error", 32'(scoreboardError), 32'd0);

        // Reset discards pending write to x4
        issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 5'd4;
        memValid = 1'b1; memRegWrite = 1'b1; memRd = 5'd4;
        cyc();
        idle(); reset = 1'b1; issueValid = 1'b1; issueRs1 = 5'd4;
        cyc();
        #1;
        chk("d36_stall", 32'(hazardStall), 32'd0);
        chk("d36_rw", 32'(registerWrite), 32'd0);
        cyc();
        reset = 1'b0;

        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            issueValid    = $urandom_range(0, 1) == 1;
            issueRegWrite = $urandom_range(0, 3) != 0;
            issueRd       = 5'($urandom_range(0, 7));
            issueRs1      = 5'($urandom_range(0, 7));
            issueRs2      = 5'($urandom_range(0, 7));
            memValid      = $urandom_range(0, 2) != 0;
            memRegWrite   = $urandom_range(0, 3) != 0;
            memRd         = 5'($urandom_range(0, 7));
            memWbSel      = 2'($urandom_range(0, 3));
            memAluResult  = $urandom;
            memReadData   = $urandom;
            memPcPlus4    = $urandom;
            cyc();
        end
        reset = 1'b0; idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
